bram_boot_loader: RTL and testbench

- Sits between the host UART byte stream, the soft-processor program block RAM, and the processor's reset input.
- After reset it holds the CPU in reset. It either receives a framed program image and writes it into BRAM as little-endian 32-bit words, or times out and boots the existing BRAM contents.
- Once loading finishes, it hands the BRAM port to the CPU and releases CPU reset.
- This is the hardware counterpart of the simulation-only memory preload.

---
 rtl/bram_boot_loader_if.sv | 29 ++
 rtl/bram_boot_loader.sv | 174 +++++++++++++++++
 tb/tb_bram_boot_loader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/bram_boot_loader_if.sv
// Byte stream, CPU-side BRAM port and physical BRAM port of the boot loader.
// The loader uses the slave view; the host/CPU/BRAM environment uses the master view.
interface bram_boot_loader_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              cpu_bram_en;
    logic [3:0]        cpu_bram_we;
    logic [ADDR_W-1:0] cpu_bram_addr;
    logic [31:0]       cpu_bram_din;
    logic [31:0]       cpu_bram_dout;
    logic              bram_en;
    logic [3:0]        bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_din;
    logic [31:0]       bram_dout;

    modport slave (
        input  s_data, s_valid, cpu_bram_en, cpu_bram_we, cpu_bram_addr, cpu_bram_din, bram_dout,
        output s_ready, cpu_bram_dout, bram_en, bram_we, bram_addr, bram_din
    );

    modport master (
        output s_data, s_valid, cpu_bram_en, cpu_bram_we, cpu_bram_addr, cpu_bram_din, bram_dout,
        input  s_ready, cpu_bram_dout, bram_en, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/bram_boot_loader.sv
// UART-framed program loader: holds the CPU in reset, writes a framed image into
// program BRAM (or times out), then hands the BRAM port to the CPU and releases reset.
module bram_boot_loader #(
    parameter int          ADDR_W       = 14,
    parameter int          BOOT_TIMEOUT = 50000000,
    parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
    input  logic                clk_50M,
    input  logic                ext_reset_n,
    bram_boot_loader_if.slave   bus,
    output logic                cpu_reset_n,
    output logic                load_busy,
    output logic                load_done,
    output logic                load_err,
    output logic [ADDR_W:0]     words_loaded
);
    localparam int TO_W = $clog2(BOOT_TIMEOUT) + 1;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(BOOT_TIMEOUT - 1);
    localparam logic [16:0]     CAP      = 17'(1) << ADDR_W;
    localparam logic [ADDR_W:0] WORD_ONE = 1;

    localparam logic [2:0] WAIT_HDR = 3'd0;
    localparam logic [2:0] LEN0     = 3'd1;
    localparam logic [2:0] LEN1     = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;
    localparam logic [2:0] CSUM     = 3'd4;
    localparam logic [2:0] ERR      = 3'd5;
    localparam logic [2:0] RUN      = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;

    logic        accept, hdr, run;
    logic [15:0] len_full;

    assign bus.s_ready = ext_reset_n;
    assign accept      = bus.s_valid & bus.s_ready;
    assign hdr         = accept && (bus.s_data == HDR_BYTE);
    assign len_full    = {bus.s_data, len_q[7:0]};
    assign run         = (state_q == RUN);

    always_comb begin
        state_d     = state_q;
        to_cnt_d    = '0;
        len_d       = len_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        csum_d      = csum_q;
        words_d     = words_q;
        done_d      = done_q;
        err_d       = err_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        // Drops on the same edge as a reload header so the CPU never sees the loader's port.
        cpu_rst_n_d = run && !hdr;

        case (state_q)
            WAIT_HDR: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (!hdr && to_cnt_q == TO_LAST) state_d = RUN;
            end
            LEN0: if (accept) begin
                len_d[7:0] = bus.s_data;
                state_d    = LEN1;
            end
            LEN1: if (accept) begin
                len_d[15:8] = bus.s_data;
                if (len_full == 16'd0) begin
                    state_d = CSUM;
                end else if ({1'b0, len_full} > CAP) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: if (accept) begin
                csum_d     = csum_q + bus.s_data;
                byte_idx_d = byte_idx_q + 2'd1;
                case (byte_idx_q)
                    2'd0: word_d[7:0]   = bus.s_data;
                    2'd1: word_d[15:8]  = bus.s_data;
                    2'd2: word_d[23:16] = bus.s_data;
                    default: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = words_q[ADDR_W-1:0];
                        wr_data_d = {bus.s_data, word_q};
                        words_d   = words_q + WORD_ONE;
                        if (17'(words_q) + 17'd1 == 17'(len_q)) state_d = CSUM;
                    end
                endcase
            end
            CSUM: if (accept) begin
                if (bus.s_data == csum_q) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                end else begin
                    state_d = ERR;
                    done_d  = 1'b0;
                    err_d   = 1'b1;
                end
            end
            default: ;
        endcase

        // A header restarts framing from any idle-ish state and clears per-frame status.
        if (hdr && (state_q == WAIT_HDR || state_q == ERR || state_q == RUN)) begin
            state_d    = LEN0;
            to_cnt_d   = '0;
            done_d     = 1'b0;
            err_d      = 1'b0;
            words_d    = '0;
            csum_d     = '0;
            byte_idx_d = '0;
        end
    end

    always_ff @(posedge clk_50M or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            state_q     <= WAIT_HDR;
            to_cnt_q    <= '0;
            len_q       <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            words_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            len_q       <= len_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            words_q     <= words_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.bram_en       = run ? bus.cpu_bram_en   : wr_en_q;
    assign bus.bram_we       = run ? bus.cpu_bram_we   : {4{wr_en_q}};
    assign bus.bram_addr     = run ? bus.cpu_bram_addr : wr_addr_q;
    assign bus.bram_din      = run ? bus.cpu_bram_din  : wr_data_q;
    assign bus.cpu_bram_dout = bus.bram_dout;

    assign cpu_reset_n  = cpu_rst_n_q;
    assign load_busy    = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA) || (state_q == CSUM);
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;
endmodule

// File: tb/tb_bram_boot_loader.sv
// Randomized frame bench for bram_boot_loader with a BRAM model and a frame-level reference.
module tb_bram_boot_loader;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int TO    = 200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_reset_n, load_busy, load_done, load_err;
    logic [AW:0]   words_loaded;

    bram_boot_loader_if #(.ADDR_W(AW)) bus ();

    bram_boot_loader #(.ADDR_W(AW), .BOOT_TIMEOUT(TO), .HDR_BYTE(8'hA5)) dut (
        .clk_50M(clk), .ext_reset_n(rst_n), .bus(bus),
        .cpu_reset_n(cpu_reset_n), .load_busy(load_busy), .load_done(load_done),
        .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [DEPTH];
    logic [31:0] mem_ref [DEPTH];
    logic [7:0]  fdat    [0:71];
    int          wr_cnt = 0;
    int          n_chk = 0, n_fail = 0;
    bit          in_wait;

    // Behavioural BRAM: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (bus.bram_en) begin
            if (|bus.bram_we) wr_cnt <= wr_cnt + 1;
            for (int b = 0; b < 4; b++)
                if (bus.bram_we[b]) mem[bus.bram_addr][8*b +: 8] <= bus.bram_din[8*b +: 8];
            bus.bram_dout <= mem[bus.bram_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        @(negedge clk);
        bus.s_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Sends header, length, 4*len data bytes (from fdat) and checksum+cdelta; checks the outcome.
    task automatic send_frame(input int len, input int cdelta, input bit rgap);
        bit          was_run, over, ok;
        int          w0;
        logic [15:0] l16;
        logic [7:0]  sum;
        was_run = cpu_reset_n;
        w0      = wr_cnt;
        l16     = 16'(len);
        over    = len > DEPTH;
        ok      = !over && (cdelta % 256 == 0);
        send_byte(8'hA5, 0);
        if (was_run) begin
            chk("reload_rst", cpu_reset_n, 0);
            bus.cpu_bram_en = 1'b1;
            bus.cpu_bram_we = 4'hF;
            #1;
            chk("own_en", bus.bram_en, 0);
            chk("own_we", bus.bram_we, 0);
            bus.cpu_bram_en = 1'b0;
            bus.cpu_bram_we = 4'h0;
        end
        chk("busy_len0", load_busy, 1);
        chk("clr_done", load_done, 0);
        chk("clr_words", words_loaded, 0);
        send_byte(l16[7:0],  rgap ? $urandom_range(0, 2) : 0);
        send_byte(l16[15:8], rgap ? $urandom_range(0, 2) : 0);
        if (!over) begin
            sum = 8'h00;
            for (int i = 0; i < 4 * len; i++) begin
                send_byte(fdat[i], rgap ? $urandom_range(0, 2) : 0);
                sum = sum + fdat[i];
            end
            for (int w = 0; w < len; w++)
                mem_ref[w] = {fdat[4*w+3], fdat[4*w+2], fdat[4*w+1], fdat[4*w]};
            send_byte(sum + 8'(cdelta), 0);
        end
        repeat (3) @(negedge clk);
        chk("done", load_done, ok);
        chk("err", load_err, !ok);
        chk("busy_end", load_busy, 0);
        chk("words", words_loaded, over ? 0 : len);
        chk("cpu_rst", cpu_reset_n, ok);
        chk("wr_pulses", wr_cnt - w0, over ? 0 : len);
        if (!over)
            for (int w = 0; w < len; w++) chk($sformatf("mem%0d", w), mem[w], mem_ref[w]);
        in_wait = 1'b0;
    endtask

    initial begin
        int          cyc;
        logic [31:0] d;
        logic [7:0]  jb;
        bit          prev;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = '0;
            mem_ref[i] = '0;
        end
        bus.s_data = '0; bus.s_valid = 1'b0; bus.bram_dout = '0;
        bus.cpu_bram_en = 1'b0; bus.cpu_bram_we = '0; bus.cpu_bram_addr = '0; bus.cpu_bram_din = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.s_ready, 0);
        chk("rst_cpu", cpu_reset_n, 0);
        chk("rst_busy", load_busy, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        chk("rst_words", words_loaded, 0);
        chk("rst_en", bus.bram_en, 0);
        chk("rst_we", bus.bram_we, 0);
        rst_n = 1'b1;
        #1 chk("ready", bus.s_ready, 1);

        // Timeout boot: CPU reset releases about BOOT_TIMEOUT+1 cycles after reset release
        cyc = 0;
        while (!cpu_reset_n && cyc < 2 * TO) begin
            @(negedge clk);
            cyc++;
        end
        chk("to_cycle", (cyc >= TO && cyc <= TO + 2) ? TO + 1 : cyc, TO + 1);
        chk("to_done", load_done, 0);
        chk("to_words", words_loaded, 0);

        // CPU owns the port in RUN
        d = $urandom;
        bus.cpu_bram_en = 1'b1; bus.cpu_bram_we = 4'h3; bus.cpu_bram_addr = 4'd5; bus.cpu_bram_din = d;
        #1;
        chk("cpu_en", bus.bram_en, 1);
        chk("cpu_we", bus.bram_we, 4'h3);
        chk("cpu_addr", bus.bram_addr, 5);
        chk("cpu_din", bus.bram_din, d);
        mem_ref[5][15:0] = d[15:0];
        @(negedge clk);
        bus.cpu_bram_we = 4'h0;
        @(negedge clk);
        chk("cpu_dout", bus.cpu_bram_dout, mem_ref[5]);
        bus.cpu_bram_en = 1'b0; bus.cpu_bram_addr = '0; bus.cpu_bram_din = '0;

        // Good frame (reload from RUN)
        for (int i = 0; i < 8; i++) fdat[i] = 8'(8'h11 * (i + 1));
        send_frame(2, 0, 1'b0);
        chk("good_w0", mem[0], 32'h44332211);
        chk("good_w1", mem[1], 32'h88776655);
        // Bad checksum, then resend
        send_frame(2, 1, 1'b0);
        send_frame(2, 0, 1'b1);
        // Oversize
        send_frame(17, 0, 1'b0);
        // Zero length recovers from ERR, then zero length reload from RUN
        send_frame(0, 0, 1'b0);
        send_frame(0, 0, 1'b0);

        // Reset mid-DATA after six data bytes
        for (int i = 0; i < 6; i++) fdat[i] = 8'($urandom);
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(fdat[i], 0);
        mem_ref[0] = {fdat[3], fdat[2], fdat[1], fdat[0]};
        rst_n = 1'b0;
        #1;
        chk("mid_words", words_loaded, 0);
        chk("mid_busy", load_busy, 0);
        chk("mid_cpu", cpu_reset_n, 0);
        chk("mid_ready", bus.s_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_mem0", mem[0], mem_ref[0]);
        in_wait = 1'b1;

        // Randomized frames with junk bytes between them
        for (int f = 0; f < 30; f++) begin
            int len, cd;
            len = $urandom_range(0, 18);
            cd  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 255) : 0;
            if (!in_wait) begin
                prev = cpu_reset_n;
                repeat ($urandom_range(0, 3)) begin
                    jb = 8'($urandom);
                    if (jb == 8'hA5) jb = 8'h5A;
                    send_byte(jb, $urandom_range(0, 1));
                end
                chk("junk_hold", cpu_reset_n, prev);
            end
            for (int i = 0; i < 4 * len && i < 72; i++) fdat[i] = 8'($urandom);
            send_frame(len, cd, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
